fb_write_scheduler: RTL

Write-side controller for the tiled framebuffer. Shares the framebuffer write port between the rasterizer's tile-write stream and an internal clear engine. The clear engine sweeps every framebuffer address with a latched clear colour. All framebuffer write outputs are registered, one beat per cycle, and sit directly on the framebuffer's `wr_*` ports in the `clk` domain.

---
 rtl/fb_pkg.sv | 54 +++++
 rtl/fb_clear_walker.sv | 40 ++++
 rtl/fb_write_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared framebuffer write-side definitions: frame geometry, derived sizes,
// the write-beat struct used by the rasterizer, the write scheduler and the
// framebuffer, the scheduler FSM state type and a helper that builds one
// clear-engine beat.
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int RESOLUTION_X  = 400;
  localparam int RESOLUTION_Y  = 300;
  localparam int PXL_BITS      = 8;
  localparam int TILE_WIDTH    = 4;
  localparam int TILE_HEIGHT   = 4;
  localparam int PXLS_PER_DATA = 4;

  localparam int PXL_PER_TILE = TILE_WIDTH * TILE_HEIGHT;
  localparam int TILE_COUNT   = RESOLUTION_X * RESOLUTION_Y / PXL_PER_TILE;
  localparam int ADDR_W       = $clog2(TILE_COUNT);
  localparam int CLEAR_BEATS  = TILE_COUNT / PXLS_PER_DATA;
  localparam int CNT_W        = $clog2(CLEAR_BEATS);

  typedef logic [PXL_PER_TILE-1:0][ADDR_W-1:0]                       tile_index_t;
  typedef logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0][PXL_BITS-1:0]  pxl_data_t;
  typedef logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0]                wr_en_t;

  typedef struct packed {
    tile_index_t tile_index;
    pxl_data_t   pxl_data;
    wr_en_t      wr_en;
  } fb_wr_beat_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // Clear beat k: every bank addresses word k*PXLS_PER_DATA, every lane
  // carries the clear colour and is enabled.
  function automatic fb_wr_beat_t clear_beat(input logic [CNT_W-1:0]    count,
                                             input logic [PXL_BITS-1:0] color);
    fb_wr_beat_t beat;
    beat = '0;
    for (int b = 0; b < PXL_PER_TILE; b++) begin
      beat.tile_index[b] = ADDR_W'(count) * ADDR_W'(PXLS_PER_DATA);
      for (int l = 0; l < PXLS_PER_DATA; l++) begin
        beat.pxl_data[b][l] = color;
      end
    end
    beat.wr_en = '1;
    return beat;
  endfunction

endpackage

// File: rtl/fb_clear_walker.sv
// ---------------------------------------------------------------------------
// fb_clear_walker
// Beat counter for the clear engine. The counter saturates on the last beat
// rather than wrapping, so a stray step can never revisit address 0.
//   clk      in   sole clock
//   reset_n  in   synchronous active-low reset
//   start    in   zero the counter for a new sweep
//   step     in   a clear beat is issued this cycle; advance
//   count    out  current beat index k
//   last     out  k is the final beat of the sweep
//   done     out  the final beat is being issued this cycle
// ---------------------------------------------------------------------------
module fb_clear_walker
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             done
);

  assign last = (count == CNT_W'(CLEAR_BEATS - 1));
  assign done = step & last;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (step && !last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// ---------------------------------------------------------------------------
// fb_write_scheduler
// Shares the framebuffer write port between the rasterizer tile-write stream
// and the clear engine. All fb_wr_* outputs are registered, one beat/cycle.
//   clk               in   sole clock
//   reset_n           in   synchronous active-low reset
//   clear_start       in   single-cycle clear request (ignored while busy)
//   clear_color       in   clear colour, latched with an accepted request
//   busy              out  clear sweep in progress
//   clear_done        out  pulse with the last clear beat on fb_wr_*
//   rs_valid/rs_ready      rasterizer beat handshake (ready decoded from state)
//   rs_tile_index, rs_pxl_data, rs_wr_en    rasterizer beat
//   fb_wr_tile_index, fb_wr_pxl_data, fb_wr_en  registered framebuffer beat
// Build option: FB_CLEAR_ON_RESET_EN - reset enters the clear sweep with
// colour 0 instead of idling, so the framebuffer is wiped after power-up.
// ---------------------------------------------------------------------------
module fb_write_scheduler
  import fb_pkg::*;
(
  input  logic                                                     clk,
  input  logic                                                     reset_n,
  input  logic                                                     clear_start,
  input  logic [PXL_BITS-1:0]                                      clear_color,
  output logic                                                     busy,
  output logic                                                     clear_done,
  input  logic                                                     rs_valid,
  output logic                                                     rs_ready,
  input  logic [PXL_PER_TILE-1:0][ADDR_W-1:0]                      rs_tile_index,
  input  logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0][PXL_BITS-1:0] rs_pxl_data,
  input  logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0]               rs_wr_en,
  output logic [PXL_PER_TILE-1:0][ADDR_W-1:0]                      fb_wr_tile_index,
  output logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0][PXL_BITS-1:0] fb_wr_pxl_data,
  output logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0]               fb_wr_en
);

`ifdef FB_CLEAR_ON_RESET_EN
  localparam fb_state_t RESET_STATE = CLEAR;
`else
  localparam fb_state_t RESET_STATE = IDLE;
`endif

  fb_state_t             state, state_next;
  fb_wr_beat_t           fb_q;
  fb_wr_beat_t           rs_beat;
  logic [PXL_BITS-1:0]   color_q;
  logic                  walk_start, walk_step;
  logic [CNT_W-1:0]      walk_count;
  logic                  walk_last, walk_done;
  logic                  accept;

  fb_clear_walker u_walker (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (walk_start),
    .step    (walk_step),
    .count   (walk_count),
    .last    (walk_last),
    .done    (walk_done)
  );

  // Ready depends on state only, so the rasterizer never sees a
  // combinational path from its own valid back to ready.
  assign rs_ready = (state == IDLE);
  assign busy     = (state == CLEAR);
  assign accept   = rs_valid & rs_ready;
  assign rs_beat  = {rs_tile_index, rs_pxl_data, rs_wr_en};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    walk_start = 1'b0;
    walk_step  = 1'b0;
    if (state == IDLE) begin
      if (clear_start) begin
        walk_start = 1'b1;
        state_next = CLEAR;
      end
    end else begin
      walk_step = 1'b1;
      if (walk_last) begin
        state_next = IDLE;
      end
    end
  end

  // Output beat register. A raster beat accepted alongside clear_start is
  // issued here in IDLE, so it lands one cycle ahead of clear beat 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fb_q       <= '0;
      clear_done <= 1'b0;
      color_q    <= '0;
    end else begin
      clear_done <= walk_done;
      if (state == IDLE) begin
        if (accept) begin
          fb_q <= rs_beat;
        end else begin
          // Address and data hold; only the enables drop.
          fb_q.wr_en <= '0;
        end
        if (clear_start) begin
          color_q <= clear_color;
        end
      end else begin
        fb_q <= clear_beat(walk_count, color_q);
      end
    end
  end

  assign fb_wr_tile_index = fb_q.tile_index;
  assign fb_wr_pxl_data   = fb_q.pxl_data;
  assign fb_wr_en         = fb_q.wr_en;

endmodule
